pong_input_conditioner: RTL
===========================

// Module: pong_input_conditioner
// PURPOSE
//  Conditions the raw player button pins before the pong game core: synchronises, debounces, edge-detects.
//  Sits between the top-level ui_in pins and the pong core.
//  Produces clean levels and one-clock press/release pulses for paddle movement and select/serve.
//  All buttons share one prescaler, so debounce cost is one small counter per button.
// PARAMETERS
//  NUM_BTNS        6       number of buttons; bit map 0..2 = p2 left/right/select, 3..5 = p1 left/right/select
//  SYNC_STAGES     2       flip-flops in each input synchroniser chain (>=2)
//  TICK_DIV        25000   clk cycles per debounce sample tick (~1 ms at 25 MHz); >=2
//  DEBOUNCE_TICKS  8       consecutive disagreeing samples needed to flip a debounced state; >=1
//  ACTIVE_LOW      0       1: a pin low means pressed (inverted after sync); 0: a pin high means pressed
// PORTS
//  clk          in   1         system clock (pixel clock domain of the pong core)
//  rst          in   1         asynchronous, active-high reset
//  en           in   1         block enable; 0 freezes prescaler and debounce state
//  btn_pins     in   NUM_BTNS  raw asynchronous button pins
//  btn_state    out  NUM_BTNS  debounced level, 1 = pressed
//  btn_press    out  NUM_BTNS  one-clk pulse on debounced 0->1
//  btn_release  out  NUM_BTNS  one-clk pulse on debounced 1->0
//  sample_tick  out  1         one-clk pulse on each debounce sample tick (for debug and testbench)
// BEHAVIOUR
//  Reset values (async assert, sync release via normal clocking):
//   - All outputs are 0.
//   - Sync chains, prescaler and debounce counters are 0.
//  Sync:
//   - Each pin passes through a SYNC_STAGES-deep flop chain; sync_out is the last stage.
//   - sync_out is XOR ACTIVE_LOW.
//   - The chain always runs, including while en=0.
//  Prescaler:
//   - Counts 0..TICK_DIV-1 while en=1, then wraps to 0.
//   - sample_tick=1 in the cycle the count equals TICK_DIV-1.
//   - While en=0 the prescaler holds its value and sample_tick=0.
//  Per-button debounce (evaluated only in cycles with sample_tick=1):
//   - If sync_out == btn_state: clear cnt.
//   - Else if cnt == DEBOUNCE_TICKS-1: toggle btn_state, clear cnt, and assert press or release
//     (registered, same edge as the state change).
//   - Else: cnt <= cnt+1.
//   - cnt width is $clog2(DEBOUNCE_TICKS) with a minimum of 1 bit. cnt never exceeds DEBOUNCE_TICKS-1.
//  Pulses:
//   - btn_press/btn_release are high for exactly one clk.
//   - A pulse coincides with the first cycle of the new btn_state; otherwise the pulse outputs are 0.
//   - press and release are never both high for the same bit.
//  Boundaries:
//   - A glitch that is not sampled on DEBOUNCE_TICKS consecutive ticks is ignored, and a single agreeing
//     sample restarts the count.
//   - Buttons are independent; simultaneous flips on several bits in one tick are all reported in that cycle.
//   - en falling mid-count: cnt and btn_state hold; counting resumes where it left off when en returns.
//   - rst mid-count or mid-pulse: everything returns to reset values immediately.
//   - The debounced state is guaranteed 0 after reset, so a button held during reset produces a press
//     after a full debounce.
//  Latency:
//   - A clean pin edge gives a pulse after SYNC_STAGES + up to TICK_DIV + (DEBOUNCE_TICKS-1)*TICK_DIV cycles.
// TESTING (bench parameters TICK_DIV=4, DEBOUNCE_TICKS=3, SYNC_STAGES=2, NUM_BTNS=6)
//  1. Reset: assert rst with pins=6'h3F.
//     -> all outputs 0 during reset.
//     -> after release, btn_state[5:0]=6'h3F on the 3rd tick and btn_press=6'h3F for exactly 1 clk.
//  2. Glitch: btn_pins[0] high for 5 clk, spanning at most 2 ticks.
//     -> btn_state stays 0 and no pulse.
//     -> then hold high: press pulse exactly 3 ticks after the last disagreeing restart.
//  3. Release: held button 3 goes low steadily.
//     -> btn_release[3]=1 for 1 clk on the 3rd tick and btn_state[3]=0 in the same cycle.
//     -> btn_press stays 0.
//  4. Enable freeze: drop en after 2 disagreeing ticks and hold it low for 50 clk.
//     -> no sample_tick, no state change.
//     -> raise en: flip on the next tick.
//  5. ACTIVE_LOW=1 instance: pins idle 6'h3F.
//     -> btn_state=0 and no pulses.
//     -> drive pin 4 low: btn_press[4] after 3 ticks.
//  6. Reset mid-count: assert rst after 2 disagreeing ticks.
//     -> counters cleared.
//     -> after release, a full 3 ticks are needed before the pulse.

Source files
------------

// File: rtl/pong_input_conditioner.sv
// Button conditioner for the pong core: per-pin synchroniser, shared debounce prescaler,
// per-button debounce counter and registered one-clock press/release pulses.
module pong_input_conditioner #(
    parameter int unsigned NUM_BTNS       = 6,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TICK_DIV       = 25000,
    parameter int unsigned DEBOUNCE_TICKS = 8,
    parameter bit          ACTIVE_LOW     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_BTNS-1:0] btn_pins,
    output logic [NUM_BTNS-1:0] btn_state,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic                sample_tick
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CNT_W   = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DEBOUNCE_TICKS - 1);

    // ------------------------------------------------------------------
    // Synchroniser chains (run regardless of en)
    // ------------------------------------------------------------------
    logic [NUM_BTNS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_BTNS-1:0] sync_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= btn_pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Normalise polarity so that 1 always means pressed downstream.
    assign sync_out = sync_q[SYNC_STAGES-1] ^ {NUM_BTNS{ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Shared sample prescaler
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_q, presc_d;

    always_comb begin
        presc_d = presc_q;
        if (en) begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign sample_tick = en & (presc_q == PRESC_MAX);

    // ------------------------------------------------------------------
    // Per-button debounce
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]    cnt_q [NUM_BTNS];
    logic [CNT_W-1:0]    cnt_d [NUM_BTNS];
    logic [NUM_BTNS-1:0] state_q, state_d;
    logic [NUM_BTNS-1:0] press_q, press_d;
    logic [NUM_BTNS-1:0] release_q, release_d;

    always_comb begin
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (sample_tick) begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (sync_out[i] == state_q[i]) begin
                    // One agreeing sample discards any partial run.
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    state_d[i]   = ~state_q[i];
                    cnt_d[i]     = '0;
                    press_d[i]   = ~state_q[i];
                    release_d[i] = state_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                cnt_q[i] <= '0;
            end
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_state   = state_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifndef SYNTHESIS
    a_press_release_exclusive : assert property (
        @(posedge clk) disable iff (rst) (btn_press & btn_release) == '0);
    a_no_tick_when_disabled : assert property (
        @(posedge clk) disable iff (rst) !en |-> !sample_tick);
`endif

endmodule
